branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DW, default 32, operand width in bits (>=8).
REQ-002 Parameter BHT_ENTRIES, default 64, branch history table depth (power of 2, >=2); IDX_W = log2(BHT_ENTRIES).
REQ-003 Parameter CNT_W, default 16, statistics counter width.
REQ-004 Ports SHALL be:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  pred_pc  in  32  fetch-stage PC for prediction lookup.
  pred_taken  out  1  prediction for pred_pc, combinational.
  req_valid  in  1  resolve request valid.
  req_ready  out  1  unit can accept a request.
  instr_code_in  in  6  operation code (beq, bne, blez, bltz, bgez, bgtz; others = non-branch).
  srcA  in  DW  operand A.
  srcB  in  DW  operand B.
  req_pc  in  32  PC of the resolving instruction.
  req_pred  in  1  prediction used at fetch for this instruction.
  flush  in  1  kill the held result and any same-cycle request.
  res_valid  out  1  result held.
  res_ready  in  1  consumer accepts result.
  branch_out  out  1  resolved taken.
  mispredict  out  1  branch_out != req_pred for a branch.
  is_branch  out  1  held op was a branch code.
  branch_cnt  out  CNT_W  resolved-branch count.
  mispred_cnt  out  CNT_W  mispredict count.

Function
REQ-005 Conditions SHALL be: beq A==B; bne A!=B; blez signed A<=0; bltz signed A<0; bgez signed A>=0; bgtz signed A>0; all on DW bits; non-branch -> not taken.
REQ-006 BHT index SHALL be pc[IDX_W+1:2] for both lookup and update.
REQ-007 Each BHT entry SHALL be a 2-bit saturating counter: SNT=0, WNT=1, WT=2, ST=3; pred_taken = entry[1].
REQ-008 Request accepted when req_valid && req_ready && !flush; req_ready = !res_valid || res_ready.
REQ-009 Latency: results SHALL appear in output register on the edge after acceptance (1 cycle); held unchanged while res_valid && !res_ready.
REQ-010 On accept of a branch: entry increments (sat. at ST) if taken, decrements (sat. at SNT) if not, written on the same accepting edge.
REQ-011 Non-branch accept: res_valid=1, branch_out=0, mispredict=0, is_branch=0, no BHT or counter change.
REQ-012 Lookup in the same cycle as an update to the same index SHALL return the pre-update value (no bypass).
REQ-013 flush SHALL clear res_valid next edge, block acceptance that cycle, suppress BHT/counter update.
REQ-014 Without a new accept, consumed result (res_valid && res_ready) SHALL clear res_valid next edge.
REQ-015 branch_cnt increments per accepted branch; mispred_cnt per accepted mispredicted branch; both saturate at all-ones.

Reset
REQ-016 On rst_n low, immediately: res_valid, branch_out, mispredict, is_branch = 0; counters = 0; all BHT entries = WNT.
REQ-017 Reset mid-operation SHALL discard the held result with no update; first accept allowed on first edge after rst_n high.

Structure
REQ-018 Operation codes and counter encodings (SNT/WNT/WT/ST) SHALL live in the shared instruction package/header.
REQ-019 Combinational compare SHALL be a sub-module branch_cmp (DW-parametrised); BHT, output register, counters in top.

Verification
REQ-020 Reset, lookup pred_pc=0x100 -> pred_taken=0; beq A=B=5 pc=0x100 pred=0 -> next cycle branch_out=1, mispredict=1, mispred_cnt=1, entry WT, pred_taken=1.
REQ-021 bltz A=0x80000000 -> taken; bgtz A=0 -> not taken; blez A=0 -> taken; bgez A=0xFFFFFFFF -> not taken.
REQ-022 Four taken beq at pc 0x40 -> entry ST, stays ST on 5th; then three not-taken -> SNT... entry WNT after two, SNT after three.
REQ-023 res_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, outputs stable, no BHT change; res_ready=1 -> next accept.
REQ-024 flush with req_valid=1 on a taken bne -> res_valid=0 next cycle, branch_cnt unchanged, entry unchanged.
REQ-025 CNT_W=4: 20 mispredicted branches -> mispred_cnt=15 held; opcode addu -> is_branch=0, counts unchanged.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared instruction definitions for the branch resolve unit: operation codes,
// 2-bit BHT counter encodings and the saturating counter update.
package branch_resolve_unit_pkg;

    typedef enum logic [5:0] {
        OP_BLTZ = 6'd1,
        OP_BGEZ = 6'd2,
        OP_BEQ  = 6'd4,
        OP_BNE  = 6'd5,
        OP_BLEZ = 6'd6,
        OP_BGTZ = 6'd7,
        OP_ADDU = 6'd33
    } op_e;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } bht_ctr_e;

    function automatic bht_ctr_e ctr_next(input bht_ctr_e cur, input logic taken);
        case (cur)
            CTR_SNT: return taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: return taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  return taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  return taken ? CTR_ST  : CTR_WT;
            default: return CTR_WNT;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_unit_branch_cmp.sv
// Combinational branch condition evaluation; signed tests use only operand A.
module branch_cmp
    import branch_resolve_unit_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [5:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          taken,
    output logic          is_branch
);

    logic a_neg_s;
    logic a_zero_s;

    assign a_neg_s  = a[DW-1];
    assign a_zero_s = (a == {DW{1'b0}});

    // Decode the operation and evaluate its condition
    always_comb begin
        taken     = 1'b0;
        is_branch = 1'b1;
        case (op)
            OP_BEQ:  taken = (a == b);
            OP_BNE:  taken = (a != b);
            OP_BLEZ: taken = a_neg_s || a_zero_s;
            OP_BLTZ: taken = a_neg_s;
            OP_BGEZ: taken = !a_neg_s;
            OP_BGTZ: taken = !a_neg_s && !a_zero_s;
            default: begin
                taken     = 1'b0;
                is_branch = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves branches through one output register, trains a
// 2-bit BHT and keeps saturating branch / mispredict statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DW          = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       instr_code_in,
    input  logic [DW-1:0]    srcA,
    input  logic [DW-1:0]    srcB,
    input  logic [31:0]      req_pc,
    input  logic             req_pred,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             branch_out,
    output logic             mispredict,
    output logic             is_branch,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int               IDX_W   = $clog2(BHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    bht_ctr_e         bht_q [BHT_ENTRIES];
    bht_ctr_e         bht_d [BHT_ENTRIES];
    logic             res_valid_q, res_valid_d;
    logic             branch_out_q, branch_out_d;
    logic             mispredict_q, mispredict_d;
    logic             is_branch_q, is_branch_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             taken_s;
    logic             cmp_is_br_s;
    logic             accept_s;
    logic             mis_s;
    logic [IDX_W-1:0] req_idx_s;

    branch_cmp #(.DW(DW)) u_cmp (
        .op        (instr_code_in),
        .a         (srcA),
        .b         (srcB),
        .taken     (taken_s),
        .is_branch (cmp_is_br_s)
    );

    // Lookup reads the registered table, so a same-cycle update is not visible
    assign pred_taken = bht_q[pred_pc[IDX_W+1:2]][1];
    assign req_ready  = !res_valid_q || res_ready;
    assign accept_s   = req_valid && req_ready && !flush;
    assign req_idx_s  = req_pc[IDX_W+1:2];
    assign mis_s      = cmp_is_br_s && (taken_s != req_pred);

    // Next-state for result register, BHT and statistics
    always_comb begin
        res_valid_d   = res_valid_q;
        branch_out_d  = branch_out_q;
        mispredict_d  = mispredict_q;
        is_branch_d   = is_branch_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        bht_d         = bht_q;
        if (flush) begin
            res_valid_d  = 1'b0;
            branch_out_d = 1'b0;
            mispredict_d = 1'b0;
            is_branch_d  = 1'b0;
        end else if (accept_s) begin
            res_valid_d  = 1'b1;
            branch_out_d = cmp_is_br_s && taken_s;
            mispredict_d = mis_s;
            is_branch_d  = cmp_is_br_s;
            if (cmp_is_br_s) begin
                bht_d[req_idx_s] = ctr_next(bht_q[req_idx_s], taken_s);
                if (branch_cnt_q != CNT_MAX) begin
                    branch_cnt_d = branch_cnt_q + CNT_ONE;
                end else begin
                    branch_cnt_d = branch_cnt_q;
                end
                if (mis_s && (mispred_cnt_q != CNT_MAX)) begin
                    mispred_cnt_d = mispred_cnt_q + CNT_ONE;
                end else begin
                    mispred_cnt_d = mispred_cnt_q;
                end
            end else begin
                bht_d = bht_q;
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q   <= 1'b0;
            branch_out_q  <= 1'b0;
            mispredict_q  <= 1'b0;
            is_branch_q   <= 1'b0;
            branch_cnt_q  <= {CNT_W{1'b0}};
            mispred_cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CTR_WNT;
            end
        end else begin
            res_valid_q   <= res_valid_d;
            branch_out_q  <= branch_out_d;
            mispredict_q  <= mispredict_d;
            is_branch_q   <= is_branch_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            bht_q         <= bht_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign branch_out  = branch_out_q;
    assign mispredict  = mispredict_q;
    assign is_branch   = is_branch_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int CW   = 4;
    localparam int NENT = 64;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pred_pc = 32'd0;
    logic          pred_taken;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [5:0]    instr_code_in = 6'd0;
    logic [31:0]   srcA = 32'd0;
    logic [31:0]   srcB = 32'd0;
    logic [31:0]   req_pc = 32'd0;
    logic          req_pred = 1'b0;
    logic          flush = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic          branch_out;
    logic          mispredict;
    logic          is_branch;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int m_bht [NENT];
    bit m_vld, m_br, m_mis, m_isb;
    int m_bc, m_mc;

    logic [5:0] ops [8];

    branch_resolve_unit #(.DW(32), .BHT_ENTRIES(NENT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .req_valid(req_valid), .req_ready(req_ready), .instr_code_in(instr_code_in),
        .srcA(srcA), .srcB(srcB), .req_pc(req_pc), .req_pred(req_pred), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .branch_out(branch_out),
        .mispredict(mispredict), .is_branch(is_branch), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_is_br(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
               (op == OP_BLTZ) || (op == OP_BGEZ) || (op == OP_BGTZ);
    endfunction

    function automatic bit ref_taken(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = $signed(a);
        if (op == OP_BEQ)  return a == b;
        if (op == OP_BNE)  return a != b;
        if (op == OP_BLEZ) return sa <= 0;
        if (op == OP_BLTZ) return sa < 0;
        if (op == OP_BGEZ) return sa >= 0;
        if (op == OP_BGTZ) return sa > 0;
        return 1'b0;
    endfunction

    function automatic int idx(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    task automatic model_reset();
        m_vld = 0; m_br = 0; m_mis = 0; m_isb = 0; m_bc = 0; m_mc = 0;
        for (int i = 0; i < NENT; i++) m_bht[i] = 1;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_branch_out", branch_out, 0);
        check_eq("rst_mispred_cnt", mispred_cnt, 0);
        check_eq("rst_branch_cnt", branch_cnt, 0);
        model_reset();
        req_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit rv, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input bit rp,
                        input bit fl, input bit rr, input logic [31:0] ppc);
        bit acc, t, isb;
        int e;
        @(negedge clk);
        req_valid = rv; instr_code_in = op; srcA = a; srcB = b; req_pc = pc;
        req_pred = rp; flush = fl; res_ready = rr; pred_pc = ppc;
        #1;
        check_eq("pred_pre", pred_taken, m_bht[idx(ppc)] >= 2);
        check_eq("req_ready", req_ready, !m_vld || rr);
        acc = rv && (!m_vld || rr) && !fl;
        if (acc) begin
            isb = ref_is_br(op);
            t   = ref_taken(op, a, b);
            if (isb) begin
                e = idx(pc);
                m_bht[e] = t ? ((m_bht[e] < 3) ? m_bht[e] + 1 : 3)
                             : ((m_bht[e] > 0) ? m_bht[e] - 1 : 0);
                m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
                if (t != rp) m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
            end
            m_vld = 1; m_br = isb && t; m_mis = isb && (t != rp); m_isb = isb;
        end else if (fl) begin
            m_vld = 0;
        end else if (m_vld && rr) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        check_eq("res_valid", res_valid, m_vld);
        if (m_vld) begin
            check_eq("branch_out", branch_out, m_br);
            check_eq("mispredict", mispredict, m_mis);
            check_eq("is_branch", is_branch, m_isb);
        end
        check_eq("branch_cnt", branch_cnt, m_bc);
        check_eq("mispred_cnt", mispred_cnt, m_mc);
        check_eq("pred_post", pred_taken, m_bht[idx(ppc)] >= 2);
    endtask

    initial begin
        ops[0] = OP_BEQ; ops[1] = OP_BNE; ops[2] = OP_BLEZ; ops[3] = OP_BLTZ;
        ops[4] = OP_BGEZ; ops[5] = OP_BGTZ; ops[6] = OP_ADDU; ops[7] = 6'd0;
        model_reset();
        do_reset();

        // Reset lookup then first mispredicted beq
        step(0, OP_ADDU, 0, 0, 0, 0, 0, 1, 32'h100);
        check_eq("r20_pred_reset", pred_taken, 0);
        step(1, OP_BEQ, 5, 5, 32'h100, 0, 0, 1, 32'h100);
        check_eq("r20_branch_out", branch_out, 1);
        check_eq("r20_mispredict", mispredict, 1);
        check_eq("r20_mispred_cnt", mispred_cnt, 1);
        check_eq("r20_pred_wt", pred_taken, 1);

        // Signed compares at the sign / zero boundaries
        step(1, OP_BLTZ, 32'h80000000, 0, 32'h200, 0, 0, 1, 32'h200);
        check_eq("r21_bltz", branch_out, 1);
        step(1, OP_BGTZ, 0, 0, 32'h200, 0, 0, 1, 32'h200);
        check_eq("r21_bgtz", branch_out, 0);
        step(1, OP_BLEZ, 0, 0, 32'h200, 0, 0, 1, 32'h200);
        check_eq("r21_blez", branch_out, 1);
        step(1, OP_BGEZ, 32'hFFFFFFFF, 0, 32'h200, 0, 0, 1, 32'h200);
        check_eq("r21_bgez", branch_out, 0);

        // Counter saturation at ST then walk down
        for (int i = 0; i < 5; i++) step(1, OP_BEQ, 7, 7, 32'h40, 1, 0, 1, 32'h40);
        check_eq("r22_st_hold", pred_taken, 1);
        step(1, OP_BEQ, 7, 8, 32'h40, 1, 0, 1, 32'h40);
        check_eq("r22_wt", pred_taken, 1);
        step(1, OP_BEQ, 7, 8, 32'h40, 1, 0, 1, 32'h40);
        check_eq("r22_wnt", pred_taken, 0);
        step(1, OP_BEQ, 7, 8, 32'h40, 1, 0, 1, 32'h40);
        check_eq("r22_snt", pred_taken, 0);

        // Back-pressure: held not-taken result, then a taken bne accepted
        step(1, OP_BEQ, 1, 2, 32'h80, 0, 0, 0, 32'h80);
        for (int i = 0; i < 3; i++) begin
            step(1, OP_BNE, 1, 2, 32'h80, 0, 0, 0, 32'h80);
            check_eq("r23_ready", req_ready, 0);
            check_eq("r23_hold", branch_out, 0);
        end
        step(1, OP_BNE, 1, 2, 32'h80, 0, 0, 1, 32'h80);
        check_eq("r23_next", branch_out, 1);

        // Flush kills a same-cycle taken bne
        do_reset();
        step(1, OP_BNE, 1, 2, 32'h100, 0, 1, 1, 32'h100);
        check_eq("r24_valid", res_valid, 0);
        check_eq("r24_cnt", branch_cnt, 0);
        check_eq("r24_entry", pred_taken, 0);

        // Statistics saturation, then a non-branch
        do_reset();
        for (int i = 0; i < 20; i++) step(1, OP_BEQ, 3, 3, 32'h300, 0, 0, 1, 32'h300);
        check_eq("r25_mc_sat", mispred_cnt, 15);
        step(1, OP_ADDU, 3, 3, 32'h300, 0, 0, 1, 32'h300);
        check_eq("r25_nonbr", is_branch, 0);
        check_eq("r25_mc_hold", mispred_cnt, 15);

        // Reset while a result is held
        step(1, OP_BEQ, 9, 9, 32'h10, 0, 0, 0, 32'h10);
        do_reset();
        step(1, OP_BEQ, 9, 9, 32'h10, 0, 0, 1, 32'h10);

        // Random traffic over a few aliasing PCs
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b, pc, ppc;
            logic [5:0]  op;
            if (n % 100 == 99) do_reset();
            op = ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: a = 32'd0;
                1: a = 32'h80000000 | $urandom;
                2: a = $urandom_range(0, 3);
                default: a = $urandom;
            endcase
            b   = ($urandom_range(0, 1) == 0) ? a : $urandom_range(0, 3);
            pc  = {$urandom_range(0, 3), 2'b00} + (($urandom_range(0, 1) == 0) ? 32'h0 : 32'h100);
            ppc = ($urandom_range(0, 1) == 0) ? pc : {$urandom_range(0, 3), 2'b00};
            step($urandom_range(0, 9) < 7, op, a, b, pc, $urandom_range(0, 1),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, ppc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
